core_pc_gen: RTL and testbench
==============================

// Module: core_pc_gen
// PURPOSE
//  Sequential PC generator for the RV32I fetch stage: owns the architectural fetch PC register.
//  Computes next PC each cycle from sequential step, EX-stage redirects (branch/JAL/JALR) or trap vector.
//  Drives a valid/ready fetch handshake toward instruction memory and a flush pulse toward IF/ID.
//  Generalises the combinational PC-update path: parametrised width/vectors, stall, alignment trap, optional BTB.
// PARAMETERS
//  XLEN          32            PC / operand width
//  RESET_VECTOR  32'h0000_0000 first fetch address after reset
//  TRAP_VECTOR   32'h0000_0100 target on misaligned redirect
//  BTB_DEPTH     8             BTB entries, power of 2 >= 2 (used only with CORE_PC_BTB_EN)
// PORTS
//  CLK            in   1     clock, rising edge
//  NRST           in   1     asynchronous active-low reset
//  STALL          in   1     hold PC (hazard unit)
//  C_TAKE_BRANCH  in   1     EX: conditional branch taken
//  ISJAL          in   1     EX: JAL
//  ISJALR         in   1     EX: JALR
//  C_MISPRED_NT   in   1     EX: predicted-taken instruction resolved not-taken
//  IDEX_PC        in   XLEN  PC of instruction in EX
//  IMM            in   XLEN  sign-extended immediate from EX
//  REG_RDATA1     in   XLEN  rs1 value from EX (forwarded)
//  IF_READY       in   1     instruction memory accepts PC
//  IF_VALID       out  1     PC is a valid fetch request
//  PC             out  XLEN  current fetch address
//  PRED_TAKEN     out  1     fetch at PC was BTB-predicted taken
//  FLUSH          out  1     one-cycle pulse: kill IF/ID and ID/EX contents
//  TRAP_MISALIGN  out  1     one-cycle pulse: redirect target misaligned
//  TRAP_ADDR      out  XLEN  offending target, valid with TRAP_MISALIGN
// BEHAVIOUR
//  Reset (NRST=0, async): PC=RESET_VECTOR, state=BOOT, IF_VALID=0, PRED_TAKEN=0, FLUSH=0, TRAP_MISALIGN=0, TRAP_ADDR=0.
//  States: BOOT (one idle cycle after reset release) -> RUN; RUN -> BUBBLE on redirect/trap; BUBBLE -> RUN after 1 cycle.
//  IF_VALID=1 only in RUN. PC advances only on accept = IF_VALID & IF_READY & !STALL.
//  Targets (mod 2^XLEN): br/jal = IDEX_PC+IMM; jalr = (REG_RDATA1+IMM) & ~1; nt-fix = IDEX_PC+4; seq = PC+4.
//  Redirect priority, registered at clock edge: (C_TAKE_BRANCH|ISJAL) > ISJALR > C_MISPRED_NT > accept > hold.
//  Redirect overrides STALL, IF_READY and state (accepted in BOOT and BUBBLE too).
//  Redirect: PC<=target, FLUSH=1 next cycle, state<=BUBBLE. Target[1:0]!=0: PC<=TRAP_VECTOR,
//   TRAP_MISALIGN=1 and TRAP_ADDR=target next cycle, FLUSH=1, state<=BUBBLE.
//  Wrap: PC=32'hFFFF_FFFC + accept -> PC=0, no trap. Redirect target 0 is legal.
//  Latency: redirect at edge N -> new PC with IF_VALID at edge N+2 (one bubble).
// CONFIGURATION
//  CORE_PC_BTB_EN defined: direct-mapped BTB of BTB_DEPTH entries {valid, tag, target};
//   index = PC[log2(BTB_DEPTH)+1:2], tag = remaining upper bits. On accept with hit: next PC = entry target, PRED_TAKEN=1.
//   Write on taken branch/JAL with aligned target (IDEX_PC -> target); clear entry on C_MISPRED_NT.
//   All valid bits cleared by reset. Write and lookup same entry same cycle: lookup sees old contents.
//  CORE_PC_BTB_EN undefined: no storage; PRED_TAKEN tied 0; C_MISPRED_NT still redirects to IDEX_PC+4.
// TESTING
//  Reset RESET_VECTOR=0x0, IF_READY=1 -> IF_VALID=0 one cycle, then PC 0x0,0x4,0x8 on consecutive cycles.
//  STALL=1 at PC=0x8 for 3 cycles -> PC held 0x8, IF_VALID stays 1; IF_READY=0 -> same hold.
//  ISJAL, IDEX_PC=0x10, IMM=0x40 during STALL -> FLUSH pulse, one bubble, PC=0x50 with IF_VALID=1.
//  ISJALR, REG_RDATA1=0x201, IMM=0x4 -> PC=0x204; ISJALR and C_TAKE_BRANCH together -> branch target wins.
//  C_TAKE_BRANCH, IDEX_PC=0x20, IMM=0x6 -> TRAP_MISALIGN=1, TRAP_ADDR=0x26, PC=0x100.
//  BTB_EN: JAL 0x30->0x80 taken, re-fetch 0x30 -> next PC 0x80, PRED_TAKEN=1; then C_MISPRED_NT -> PC=0x34.
//  NRST pulse mid-BUBBLE -> all outputs to reset values immediately, BTB invalid.

Source files
------------

// File: rtl/core_pc_gen.sv
// ---------------------------------------------------------------------------
// core_pc_gen
//
// Purpose:
//   Fetch-stage PC generator for an RV32I pipeline. Owns the architectural
//   fetch PC register and picks the next PC each cycle from one of:
//     - the sequential step (PC+4) when the current fetch is accepted
//     - an EX-stage redirect (taken branch / JAL / JALR / not-taken fix-up)
//     - the trap vector when a redirect target is misaligned
//     - a BTB-predicted target (optional build)
//   Presents the PC to instruction memory through a valid/ready handshake and
//   raises a one-cycle flush toward IF/ID and ID/EX after every redirect.
//
// Configuration macro:
//   CORE_PC_BTB_EN  when defined, adds a direct-mapped branch target buffer
//                   of BTB_DEPTH entries. When undefined there is no
//                   predictor storage and pred_taken is tied low.
//
// Parameters:
//   XLEN          PC / operand width
//   RESET_VECTOR  first fetch address after reset
//   TRAP_VECTOR   fetch address taken when a redirect target is misaligned
//   BTB_DEPTH     number of BTB entries (power of two, >= 2)
//
// Ports:
//   clk            in   rising-edge clock
//   nrst           in   asynchronous active-low reset
//   stall          in   hold the PC (hazard unit)
//   c_take_branch  in   EX: conditional branch resolved taken
//   isjal          in   EX: JAL
//   isjalr         in   EX: JALR
//   c_mispred_nt   in   EX: predicted-taken instruction resolved not-taken
//   idex_pc        in   PC of the instruction in EX
//   imm            in   sign-extended immediate from EX
//   reg_rdata1     in   forwarded rs1 value from EX
//   if_ready       in   instruction memory accepts the PC
//   if_valid       out  PC is a valid fetch request
//   pc             out  current fetch address
//   pred_taken     out  fetch at pc was reached through a BTB prediction
//   flush          out  one-cycle pulse killing IF/ID and ID/EX
//   trap_misalign  out  one-cycle pulse: redirect target was misaligned
//   trap_addr      out  offending target, valid with trap_misalign
// ---------------------------------------------------------------------------
module core_pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              BTB_DEPTH    = 8
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            stall,
    input  logic            c_take_branch,
    input  logic            isjal,
    input  logic            isjalr,
    input  logic            c_mispred_nt,
    input  logic [XLEN-1:0] idex_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] reg_rdata1,
    input  logic            if_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic            flush,
    output logic            trap_misalign,
    output logic [XLEN-1:0] trap_addr
);

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            accept;
    logic            take_br;
    logic            redirect;
    logic            misaligned;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] nt_target;
    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_next;

    logic            btb_hit;
    logic [XLEN-1:0] btb_pred_target;

    // Candidate targets. All additions wrap modulo 2^XLEN; JALR clears bit 0
    // as the ISA requires, so only bit 1 can make a JALR target misaligned.
    assign br_target   = idex_pc + imm;
    assign jalr_target = (reg_rdata1 + imm) & JALR_MASK;
    assign nt_target   = idex_pc + PC_STEP;
    assign seq_target  = pc + PC_STEP;

    assign take_br  = c_take_branch | isjal;
    assign redirect = take_br | isjalr | c_mispred_nt;

    // A fetch only happens in RUN; stall and a busy memory both hold the PC.
    assign if_valid = (state == ST_RUN);
    assign accept   = if_valid & if_ready & ~stall;

    // Redirect source priority: branch/JAL beats JALR beats the not-taken
    // fix-up. The result is only consumed when redirect is high.
    always_comb begin
        redirect_target = nt_target;
        if (take_br) begin
            redirect_target = br_target;
        end else if (isjalr) begin
            redirect_target = jalr_target;
        end else if (c_mispred_nt) begin
            redirect_target = nt_target;
        end
    end

    assign misaligned = (redirect_target[1:0] != 2'b00);

    // Next-state logic. A redirect wins over everything, including BOOT and
    // BUBBLE, and always inserts exactly one bubble before fetching resumes.
    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = ST_BUBBLE;
        end else begin
            case (state)
                ST_BOOT:   state_next = ST_RUN;
                ST_RUN:    state_next = ST_RUN;
                ST_BUBBLE: state_next = ST_RUN;
                default:   state_next = ST_BOOT;
            endcase
        end
    end

    // Next-PC selection: redirect (or trap vector) first, then the
    // predicted or sequential step on an accepted fetch, otherwise hold.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = misaligned ? TRAP_VECTOR : redirect_target;
        end else if (accept) begin
            pc_next = btb_hit ? btb_pred_target : seq_target;
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_BOOT;
            pc    <= RESET_VECTOR;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Flush and trap pulses are registered so they line up with the cycle in
    // which the redirected PC first sits in the PC register. trap_addr keeps
    // its last value between traps; it is only meaningful with trap_misalign.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            flush         <= 1'b0;
            trap_misalign <= 1'b0;
            trap_addr     <= '0;
        end else begin
            flush         <= redirect;
            trap_misalign <= redirect & misaligned;
            if (redirect && misaligned) begin
                trap_addr <= redirect_target;
            end
        end
    end

`ifdef CORE_PC_BTB_EN

    localparam int IDX_W = (BTB_DEPTH > 1) ? $clog2(BTB_DEPTH) : 1;
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_DEPTH-1:0] btb_valid;
    logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
    logic [XLEN-1:0]      btb_target [BTB_DEPTH];

    logic [IDX_W-1:0]     lookup_idx;
    logic [TAG_W-1:0]     lookup_tag;
    logic [IDX_W-1:0]     update_idx;
    logic [TAG_W-1:0]     update_tag;
    logic                 btb_write;
    logic                 btb_clear;

    // Word-aligned PCs never use bits [1:0], so the index starts at bit 2
    // and the tag is everything above the index.
    assign lookup_idx = pc[IDX_W+1:2];
    assign lookup_tag = pc[XLEN-1:IDX_W+2];
    assign update_idx = idex_pc[IDX_W+1:2];
    assign update_tag = idex_pc[XLEN-1:IDX_W+2];

    assign btb_hit         = btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_tag);
    assign btb_pred_target = btb_target[lookup_idx];

    // Only aligned taken targets are learned, so a prediction can never
    // steer fetch to a misaligned address. A taken branch/JAL in the same
    // cycle as a not-taken fix-up takes precedence and refills the entry.
    assign btb_write = take_br & (br_target[1:0] == 2'b00);
    assign btb_clear = c_mispred_nt & ~take_br;

    // Valid bits are the only BTB state that needs resetting; a cleared
    // valid bit makes stale tags and targets harmless. The array is written
    // at the clock edge, so a same-cycle lookup still sees the old entry.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            btb_valid <= '0;
        end else if (btb_write) begin
            btb_valid[update_idx] <= 1'b1;
        end else if (btb_clear) begin
            btb_valid[update_idx] <= 1'b0;
        end
    end

    // Tag and target storage, no reset required.
    always_ff @(posedge clk) begin
        if (btb_write) begin
            btb_tag[update_idx]    <= update_tag;
            btb_target[update_idx] <= br_target;
        end
    end

    // pred_taken describes the address now in the PC register: set when it
    // was reached through a BTB hit, cleared by any other PC update.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pred_taken <= 1'b0;
        end else if (redirect) begin
            pred_taken <= 1'b0;
        end else if (accept) begin
            pred_taken <= btb_hit;
        end
    end

`else

    // No predictor: fetch always steps sequentially and never predicts.
    assign btb_hit         = 1'b0;
    assign btb_pred_target = '0;
    assign pred_taken      = 1'b0;

`endif

endmodule

// File: tb/tb_core_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_core_pc_gen
//
// Purpose:
//   Self-checking bench for core_pc_gen. Each scenario task drives the EX
//   redirect inputs and the fetch handshake, pushes the fetch addresses it
//   expects into a queue, and pops them as the DUT presents valid fetches.
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_core_pc_gen;

    logic        clk;
    logic        nrst;
    logic        stall;
    logic        c_take_branch;
    logic        isjal;
    logic        isjalr;
    logic        c_mispred_nt;
    logic [31:0] idex_pc;
    logic [31:0] imm;
    logic [31:0] reg_rdata1;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic        flush;
    logic        trap_misalign;
    logic [31:0] trap_addr;

    int          checks;
    int          errors;
    logic [31:0] expq[$];
    logic [31:0] expv;

    core_pc_gen dut (
        .clk           (clk),
        .nrst          (nrst),
        .stall         (stall),
        .c_take_branch (c_take_branch),
        .isjal         (isjal),
        .isjalr        (isjalr),
        .c_mispred_nt  (c_mispred_nt),
        .idex_pc       (idex_pc),
        .imm           (imm),
        .reg_rdata1    (reg_rdata1),
        .if_ready      (if_ready),
        .if_valid      (if_valid),
        .pc            (pc),
        .pred_taken    (pred_taken),
        .flush         (flush),
        .trap_misalign (trap_misalign),
        .trap_addr     (trap_addr)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a wedged DUT cannot hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got running required finished");
        $fatal(1, "[TB] watchdog");
    end

    // Drop all redirect strobes back to idle.
    task automatic clear_redirects();
        c_take_branch = 1'b0;
        isjal         = 1'b0;
        isjalr        = 1'b0;
        c_mispred_nt  = 1'b0;
    endtask

    // Reset values, then the single BOOT cycle with if_valid low.
    task automatic test_reset();
        nrst       = 1'b0;
        stall      = 1'b0;
        if_ready   = 1'b1;
        idex_pc    = '0;
        imm        = '0;
        reg_rdata1 = '0;
        clear_redirects();
        #2;
        checks++;
        if (pc !== 32'h0 || if_valid !== 1'b0 || flush !== 1'b0 ||
            trap_misalign !== 1'b0 || trap_addr !== 32'h0 || pred_taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values got pc=%h v=%b f=%b t=%b ta=%h p=%b required pc=0 all zero",
                     pc, if_valid, flush, trap_misalign, trap_addr, pred_taken);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL boot_idle got if_valid=%b required 0", if_valid);
        end
    endtask

    // Sequential fetch 0x0, 0x4, 0x8 right after BOOT.
    task automatic test_sequential();
        expq.push_back(32'h0);
        expq.push_back(32'h4);
        expq.push_back(32'h8);
        for (int c = 0; c < 6 && expq.size() > 0; c++) begin
            @(negedge clk);
            if (if_valid) begin
                expv = expq.pop_front();
                checks++;
                if (pc !== expv) begin
                    errors++;
                    $display("[TB] FAIL seq_pc got %h required %h", pc, expv);
                end
            end
        end
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL seq_timeout got %0d pending required 0", expq.size());
            expq.delete();
        end
        stall = 1'b1;
    endtask

    // Hold at 0x8 under stall, then under if_ready low.
    task automatic test_stall();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (pc !== 32'h8 || if_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_hold cycle %0d got pc=%h v=%b required pc=00000008 v=1",
                         c, pc, if_valid);
            end
            if (c == 2) begin
                stall    = 1'b0;
                if_ready = 1'b0;
            end
        end
        if_ready = 1'b1;
        stall    = 1'b1;
    endtask

    // JAL while stalled: flush, one bubble, then 0x50 with if_valid.
    task automatic test_jal_during_stall();
        isjal   = 1'b1;
        idex_pc = 32'h10;
        imm     = 32'h40;
        @(negedge clk);
        clear_redirects();
        stall = 1'b0;
        checks++;
        if (flush !== 1'b1 || if_valid !== 1'b0 || pc !== 32'h50) begin
            errors++;
            $display("[TB] FAIL jal_bubble got f=%b v=%b pc=%h required f=1 v=0 pc=00000050",
                     flush, if_valid, pc);
        end
        expq.push_back(32'h50);
        expq.push_back(32'h54);
        for (int c = 0; c < 6 && expq.size() > 0; c++) begin
            @(negedge clk);
            if (if_valid) begin
                expv = expq.pop_front();
                checks++;
                if (pc !== expv || flush !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL jal_pc got pc=%h f=%b required pc=%h f=0", pc, flush, expv);
                end
            end
        end
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL jal_timeout got %0d pending required 0", expq.size());
            expq.delete();
        end
    endtask

    // JALR target with bit 0 cleared, then branch beating JALR.
    task automatic test_jalr_priority();
        isjalr     = 1'b1;
        reg_rdata1 = 32'h201;
        imm        = 32'h4;
        @(negedge clk);
        clear_redirects();
        checks++;
        if (flush !== 1'b1 || pc !== 32'h204) begin
            errors++;
            $display("[TB] FAIL jalr_target got f=%b pc=%h required f=1 pc=00000204", flush, pc);
        end
        expq.push_back(32'h204);
        for (int c = 0; c < 4 && expq.size() > 0; c++) begin
            @(negedge clk);
            if (if_valid) begin
                expv = expq.pop_front();
                checks++;
                if (pc !== expv) begin
                    errors++;
                    $display("[TB] FAIL jalr_pc got %h required %h", pc, expv);
                end
            end
        end
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL jalr_timeout got %0d pending required 0", expq.size());
            expq.delete();
        end

        isjalr        = 1'b1;
        c_take_branch = 1'b1;
        idex_pc       = 32'h100;
        imm           = 32'h20;
        reg_rdata1    = 32'h400;
        @(negedge clk);
        clear_redirects();
        expq.push_back(32'h120);
        expq.push_back(32'h124);
        for (int c = 0; c < 6 && expq.size() > 0; c++) begin
            @(negedge clk);
            if (if_valid) begin
                expv = expq.pop_front();
                checks++;
                if (pc !== expv) begin
                    errors++;
                    $display("[TB] FAIL branch_over_jalr got %h required %h", pc, expv);
                end
            end
        end
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL prio_timeout got %0d pending required 0", expq.size());
            expq.delete();
        end
    endtask

    // Misaligned branch target traps to 0x100 and reports 0x26.
    task automatic test_misalign();
        c_take_branch = 1'b1;
        idex_pc       = 32'h20;
        imm           = 32'h6;
        @(negedge clk);
        clear_redirects();
        checks++;
        if (trap_misalign !== 1'b1 || trap_addr !== 32'h26 || flush !== 1'b1 ||
            pc !== 32'h100 || if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign_trap got t=%b ta=%h f=%b pc=%h v=%b required t=1 ta=00000026 f=1 pc=00000100 v=0",
                     trap_misalign, trap_addr, flush, pc, if_valid);
        end
        expq.push_back(32'h100);
        for (int c = 0; c < 4 && expq.size() > 0; c++) begin
            @(negedge clk);
            if (if_valid) begin
                expv = expq.pop_front();
                checks++;
                if (pc !== expv || trap_misalign !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL misalign_resume got pc=%h t=%b required pc=%h t=0",
                             pc, trap_misalign, expv);
                end
            end
        end
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL misalign_timeout got %0d pending required 0", expq.size());
            expq.delete();
        end
    endtask

    // PC wraps from 0xFFFF_FFFC to 0 without a trap; redirect to 0 is legal.
    task automatic test_wrap();
        isjal   = 1'b1;
        idex_pc = 32'hFFFF_FFF0;
        imm     = 32'hC;
        @(negedge clk);
        clear_redirects();
        expq.push_back(32'hFFFF_FFFC);
        expq.push_back(32'h0);
        expq.push_back(32'h4);
        for (int c = 0; c < 6 && expq.size() > 0; c++) begin
            @(negedge clk);
            if (if_valid) begin
                expv = expq.pop_front();
                checks++;
                if (pc !== expv || trap_misalign !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL wrap_pc got pc=%h t=%b required pc=%h t=0", pc, trap_misalign, expv);
                end
            end
        end
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL wrap_timeout got %0d pending required 0", expq.size());
            expq.delete();
        end

        isjalr     = 1'b1;
        reg_rdata1 = 32'h0;
        imm        = 32'h0;
        @(negedge clk);
        clear_redirects();
        checks++;
        if (trap_misalign !== 1'b0 || flush !== 1'b1 || pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL zero_target got t=%b f=%b pc=%h required t=0 f=1 pc=00000000",
                     trap_misalign, flush, pc);
        end
        @(negedge clk);
    endtask

    // Not-taken fix-up redirects to IDEX_PC+4.
    task automatic test_mispred();
        c_mispred_nt = 1'b1;
        idex_pc      = 32'h200;
        @(negedge clk);
        clear_redirects();
        expq.push_back(32'h204);
        for (int c = 0; c < 4 && expq.size() > 0; c++) begin
            @(negedge clk);
            if (if_valid) begin
                expv = expq.pop_front();
                checks++;
                if (pc !== expv || pred_taken !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mispred_pc got pc=%h p=%b required pc=%h p=0", pc, pred_taken, expv);
                end
            end
        end
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL mispred_timeout got %0d pending required 0", expq.size());
            expq.delete();
        end
    endtask

`ifdef CORE_PC_BTB_EN
    // Learn 0x30 -> 0x80, predict it on re-fetch, then unlearn on mispredict.
    task automatic test_btb();
        isjal   = 1'b1;
        idex_pc = 32'h30;
        imm     = 32'h50;
        @(negedge clk);
        clear_redirects();
        @(negedge clk);
        isjalr     = 1'b1;
        reg_rdata1 = 32'h30;
        imm        = 32'h0;
        @(negedge clk);
        clear_redirects();
        expq.push_back(32'h30);
        for (int c = 0; c < 4 && expq.size() > 0; c++) begin
            @(negedge clk);
            if (if_valid) begin
                expv = expq.pop_front();
                checks++;
                if (pc !== expv) begin
                    errors++;
                    $display("[TB] FAIL btb_refetch got %h required %h", pc, expv);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (pc !== 32'h80 || pred_taken !== 1'b1) begin
            errors++;
            $display("[TB] FAIL btb_predict got pc=%h p=%b required pc=00000080 p=1", pc, pred_taken);
        end
        c_mispred_nt = 1'b1;
        idex_pc      = 32'h30;
        @(negedge clk);
        clear_redirects();
        checks++;
        if (pc !== 32'h34 || pred_taken !== 1'b0 || flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL btb_fixup got pc=%h p=%b f=%b required pc=00000034 p=0 f=1",
                     pc, pred_taken, flush);
        end
        @(negedge clk);
        isjalr     = 1'b1;
        reg_rdata1 = 32'h30;
        @(negedge clk);
        clear_redirects();
        expq.push_back(32'h30);
        expq.push_back(32'h34);
        for (int c = 0; c < 6 && expq.size() > 0; c++) begin
            @(negedge clk);
            if (if_valid) begin
                expv = expq.pop_front();
                checks++;
                if (pc !== expv || pred_taken !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL btb_cleared got pc=%h p=%b required pc=%h p=0", pc, pred_taken, expv);
                end
            end
        end
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL btb_timeout got %0d pending required 0", expq.size());
            expq.delete();
        end
    endtask
`else
    // Without the predictor pred_taken never rises.
    task automatic test_btb();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (pred_taken !== 1'b0) begin
                errors++;
                $display("[TB] FAIL no_btb_pred got %b required 0", pred_taken);
            end
        end
    endtask
`endif

    // Reset asserted during the bubble after a JAL 0x30 -> 0x80; outputs
    // return to reset values at once, and the re-run from 0 fetches 0x34
    // after 0x30 because the learned entry was dropped.
    task automatic test_reset_mid_bubble();
        isjal   = 1'b1;
        idex_pc = 32'h30;
        imm     = 32'h50;
        @(negedge clk);
        clear_redirects();
        nrst = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0 || if_valid !== 1'b0 || flush !== 1'b0 ||
            trap_misalign !== 1'b0 || trap_addr !== 32'h0 || pred_taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got pc=%h v=%b f=%b t=%b ta=%h p=%b required pc=0 all zero",
                     pc, if_valid, flush, trap_misalign, trap_addr, pred_taken);
        end
        @(negedge clk);
        nrst = 1'b1;
        for (int a = 0; a <= 32'h34; a += 4) begin
            expq.push_back(32'(a));
        end
        for (int c = 0; c < 24 && expq.size() > 0; c++) begin
            @(negedge clk);
            if (if_valid) begin
                expv = expq.pop_front();
                checks++;
                if (pc !== expv || pred_taken !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL post_reset_pc got pc=%h p=%b required pc=%h p=0", pc, pred_taken, expv);
                end
            end
        end
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL post_reset_timeout got %0d pending required 0", expq.size());
            expq.delete();
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_jal_during_stall();
        test_jalr_priority();
        test_misalign();
        test_wrap();
        test_mispred();
        test_btb();
        test_reset_mid_bubble();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
